// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of one block RAM with a 2-cycle read path.
// One access is granted per cycle. Read data is steered back to the issuer by a 2-stage tag pipeline.
module bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid1,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic                  last_grant_q, last_grant_d;
    logic                  tag0_vld_q, tag0_vld_d;
    logic                  tag0_id_q, tag0_id_d;
    logic                  tag1_vld_q, tag1_vld_d;
    logic                  tag1_id_q, tag1_id_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] din_hold_q, din_hold_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  gnt_valid;
    logic                  gnt_id;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  rv0, rv1;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        gnt_valid = (req0 | req1) & ~rst;
        gnt_id    = (req0 & req1) ? ~last_grant_q : req1;
        win_we    = gnt_id ? we1 : we0;
        win_addr  = gnt_id ? addr1 : addr0;
        win_wdata = gnt_id ? wdata1 : wdata0;
    end

    always_comb begin
        last_grant_d = gnt_valid ? gnt_id : last_grant_q;
        addr_hold_d  = gnt_valid ? win_addr : addr_hold_q;
        din_hold_d   = gnt_valid ? win_wdata : din_hold_q;
        tag0_vld_d   = gnt_valid & ~win_we;
        tag0_id_d    = gnt_id;
        tag1_vld_d   = tag0_vld_q;
        tag1_id_d    = tag0_id_q;
    end

    // Stage 1 lines up with the cycle in which ram_dout carries the read word.
    always_comb begin
        rv0      = tag1_vld_q & ~tag1_id_q & ~rst;
        rv1      = tag1_vld_q & tag1_id_q & ~rst;
        rdata0_d = rv0 ? ram_dout : rdata0_q;
        rdata1_d = rv1 ? ram_dout : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            tag0_vld_q   <= 1'b0;
            tag0_id_q    <= 1'b0;
            tag1_vld_q   <= 1'b0;
            tag1_id_q    <= 1'b0;
            addr_hold_q  <= '0;
            din_hold_q   <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            tag0_vld_q   <= tag0_vld_d;
            tag0_id_q    <= tag0_id_d;
            tag1_vld_q   <= tag1_vld_d;
            tag1_id_q    <= tag1_id_d;
            addr_hold_q  <= addr_hold_d;
            din_hold_q   <= din_hold_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0      = gnt_valid & ~gnt_id;
    assign ack1      = gnt_valid & gnt_id;
    assign ram_en    = ~rst;
    assign ram_we    = gnt_valid & win_we;
    assign ram_waddr = rst ? '0 : addr_hold_d;
    assign ram_raddr = rst ? '0 : addr_hold_d;
    assign ram_din   = rst ? '0 : din_hold_d;
    assign rvalid0   = rv0;
    assign rvalid1   = rv1;
    assign rdata0    = rst ? '0 : rdata0_d;
    assign rdata1    = rst ? '0 : rdata1_d;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural 2-cycle BRAM, directed scenarios and a randomized
// two-port run checked against a shadow memory and an expected-read queue.
module tb_bram_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_din, ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_id_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_p1, ram_p2;

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural block RAM: address edge, then one output register
    assign ram_dout = ram_p2;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_waddr] <= ram_din;
            ram_p1 <= ram_mem[ram_raddr];
            ram_p2 <= ram_p1;
        end
    end

    // Scoreboard: accepted reads push the shadow value, rvalid pops and compares
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_id_q.delete();
            exp_cyc_q.delete();
        end else begin
            if (ack0 || ack1) begin
                n_checks++;
                if (ack0 && ack1) begin
                    n_fail++;
                    $display("FAIL both_ack: ack0=%0b ack1=%0b, required at most one", ack0, ack1);
                end
            end
            if (rvalid0 || rvalid1) begin
                n_checks++;
                if (rvalid0 && rvalid1) begin
                    n_fail++;
                    $display("FAIL both_rvalid at cycle %0d", cyc);
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid_unexpected: rvalid0=%0b rvalid1=%0b at cycle %0d", rvalid0, rvalid1, cyc);
                end else begin
                    logic [DW-1:0] ed;
                    logic          eid;
                    int            ec;
                    ed  = exp_q.pop_front();
                    eid = exp_id_q.pop_front();
                    ec  = exp_cyc_q.pop_front();
                    if (rvalid1 !== eid || cyc != ec || (eid ? rdata1 : rdata0) !== ed) begin
                        n_fail++;
                        $display("FAIL read_data: got port %0d data %h cycle %0d, required port %0d data %h cycle %0d",
                                 rvalid1, (rvalid1 ? rdata1 : rdata0), cyc, eid, ed, ec);
                    end
                end
            end
            if (ack0) begin
                n_checks++;
                if (ram_we !== we0 || ram_waddr !== addr0 || ram_raddr !== addr0 || ram_din !== wdata0) begin
                    n_fail++;
                    $display("FAIL route0: we=%0b wa=%h ra=%h din=%h, required we=%0b a=%h din=%h",
                             ram_we, ram_waddr, ram_raddr, ram_din, we0, addr0, wdata0);
                end
                if (we0) shadow[addr0] = wdata0;
                else begin
                    exp_q.push_back(shadow[addr0]);
                    exp_id_q.push_back(1'b0);
                    exp_cyc_q.push_back(cyc + 2);
                end
            end
            if (ack1) begin
                n_checks++;
                if (ram_we !== we1 || ram_waddr !== addr1 || ram_raddr !== addr1 || ram_din !== wdata1) begin
                    n_fail++;
                    $display("FAIL route1: we=%0b wa=%h ra=%h din=%h, required we=%0b a=%h din=%h",
                             ram_we, ram_waddr, ram_raddr, ram_din, we1, addr1, wdata1);
                end
                if (we1) shadow[addr1] = wdata1;
                else begin
                    exp_q.push_back(shadow[addr1]);
                    exp_id_q.push_back(1'b1);
                    exp_cyc_q.push_back(cyc + 2);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic idle(input int n);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        repeat (n) tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(1008, 1023));
        return AW'($urandom_range(0, 15));
    endfunction

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({ack0, ack1, rvalid0, rvalid1, ram_en, ram_we} !== 6'b0 || ram_waddr !== '0 ||
            ram_raddr !== '0 || ram_din !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs ack=%0b%0b rv=%0b%0b en=%0b we=%0b wa=%h ra=%h din=%h rd0=%h rd1=%h, required all 0",
                     name, ack0, ack1, rvalid0, rvalid1, ram_en, ram_we, ram_waddr, ram_raddr, ram_din, rdata0, rdata1);
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b1, 1'b1, 10'h003, '1);
        drive1(1'b1, 1'b0, 10'h004, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_outputs");
        end
        tick();
        rst = 1'b0;
        idle(0);
        @(negedge clk);
        n_checks++;
        if (ram_en !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: en=%0b ack0=%0b ack1=%0b, required 1 0 0", ram_en, ack0, ack1);
        end
        tick();
    endtask

    task automatic test_contention();
        drive0(1'b1, 1'b1, 10'h001, 32'h1111_1111);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b1) begin n_fail++; $display("FAIL cont_wr0: ack0=%0b required 1", ack0); end
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b1, 10'h002, 32'h2222_2222);
        @(negedge clk);
        n_checks++;
        if (ack1 !== 1'b1) begin n_fail++; $display("FAIL cont_wr1: ack1=%0b required 1", ack1); end
        tick();
        drive0(1'b1, 1'b0, 10'h001, '0);
        drive1(1'b1, 1'b0, 10'h002, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 6) begin
                n_checks++;
                if (ack0 !== (i % 2 == 0) || ack1 !== (i % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL cont_ack[%0d]: ack0=%0b ack1=%0b, required %0b %0b", i, ack0, ack1, i % 2 == 0, i % 2 == 1);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if (rvalid0 !== (i % 2 == 0) || rvalid1 !== (i % 2 == 1) ||
                    (i % 2 == 0 && rdata0 !== 32'h1111_1111) || (i % 2 == 1 && rdata1 !== 32'h2222_2222)) begin
                    n_fail++;
                    $display("FAIL cont_rvalid[%0d]: rv0=%0b rv1=%0b rd0=%h rd1=%h", i, rvalid0, rvalid1, rdata0, rdata1);
                end
            end
            tick();
            if (i == 5) idle(0);
        end
        idle(2);
    endtask

    task automatic test_write_read();
        drive0(1'b1, 1'b1, 10'h005, 32'hA5A5_A5A5);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || ram_we !== 1'b1 || ram_waddr !== 10'h005 ||
            ram_din !== 32'hA5A5_A5A5 || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_accept: ack0=%0b ack1=%0b we=%0b wa=%h din=%h rv0=%0b", ack0, ack1, ram_we, ram_waddr, ram_din, rvalid0);
        end
        tick();
        drive0(1'b1, 1'b0, 10'h005, '0);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b1 || ram_we !== 1'b0 || ram_raddr !== 10'h005) begin
            n_fail++;
            $display("FAIL rd_accept: ack0=%0b we=%0b ra=%h, required 1 0 005", ack0, ram_we, ram_raddr);
        end
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rd_early: rvalid0=%0b required 0", rvalid0); end
        tick();
        @(negedge clk);
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL rd_data: rvalid0=%0b rdata0=%h, required 1 a5a5a5a5", rvalid0, rdata0);
        end
        tick();
        idle(2);
    endtask

    task automatic test_last_grant();
        drive1(1'b1, 1'b0, 10'h007, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
                n_fail++;
                $display("FAIL solo1[%0d]: ack0=%0b ack1=%0b, required 0 1", i, ack0, ack1);
            end
            tick();
        end
        drive0(1'b1, 1'b0, 10'h008, '0);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_after_solo1: ack0=%0b ack1=%0b, required 1 0", ack0, ack1);
        end
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (ack1 !== 1'b1) begin n_fail++; $display("FAIL pending1: ack1=%0b required 1", ack1); end
        tick();
        idle(3);
    endtask

    task automatic test_top_address();
        logic seen_rv1;
        drive1(1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
        @(negedge clk);
        n_checks++;
        if (ack1 !== 1'b1 || ram_waddr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL top_wr: ack1=%0b wa=%h, required 1 3ff", ack1, ram_waddr);
        end
        tick();
        drive1(1'b0, 1'b0, '0, '0);
        drive0(1'b1, 1'b0, 10'h3FF, '0);
        @(negedge clk);
        seen_rv1 = rvalid1;
        n_checks++;
        if (ack0 !== 1'b1 || ram_raddr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL top_rd: ack0=%0b ra=%h, required 1 3ff", ack0, ram_raddr);
        end
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        seen_rv1 |= rvalid1;
        tick();
        @(negedge clk);
        seen_rv1 |= rvalid1;
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL top_data: rvalid0=%0b rdata0=%h, required 1 12345678", rvalid0, rdata0);
        end
        tick();
        @(negedge clk);
        seen_rv1 |= rvalid1;
        n_checks++;
        if (seen_rv1 !== 1'b0) begin n_fail++; $display("FAIL top_rvalid1: seen=%0b required 0", seen_rv1); end
        tick();
        idle(2);
    endtask

    task automatic test_reset_mid();
        drive0(1'b1, 1'b0, 10'h005, '0);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b1) begin n_fail++; $display("FAIL mid_rd: ack0=%0b required 1", ack0); end
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset_outputs");
        tick();
        rst = 1'b0;
        drive0(1'b1, 1'b0, 10'h005, '0);
        drive1(1'b1, 1'b0, 10'h3FF, '0);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: ack0=%0b ack1=%0b rvalid0=%0b, required 1 0 0", ack0, ack1, rvalid0);
        end
        tick();
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (ack1 !== 1'b1 || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after2: ack1=%0b rvalid0=%0b, required 1 0", ack1, rvalid0);
        end
        tick();
        idle(4);
    endtask

    task automatic test_random();
        logic g0, g1;
        int   n0, n1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            g0 = ack0;
            g1 = ack1;
            n0 += int'(g0);
            n1 += int'(g1);
            tick();
            if (!req0 || g0) begin
                if ($urandom_range(0, 9) < 7) drive0(1'b1, $urandom_range(0, 9) < 4, rand_addr(), $urandom);
                else drive0(1'b0, 1'b0, '0, '0);
            end
            if (!req1 || g1) begin
                if ($urandom_range(0, 9) < 7) drive1(1'b1, $urandom_range(0, 9) < 4, rand_addr(), $urandom);
                else drive1(1'b0, 1'b0, '0, '0);
            end
        end
        idle(0);
        n_checks++;
        if (n0 < 100 || n1 < 100) begin
            n_fail++;
            $display("FAIL rand_share: grants0=%0d grants1=%0d, required both >= 100", n0, n1);
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_p1 = '0;
        ram_p2 = '0;
        rst = 1'b1;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        test_reset();
        test_contention();
        test_write_read();
        test_last_grant();
        test_top_address();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter for one single-port-style block RAM.
- Target RAM: separate write/read address inputs, common enable, 2-cycle registered read path.
- Accepts at most one read or write per cycle, drives the RAM ports and routes returned read data to the issuing requester with a valid strobe.
- Sits between two bus masters (e.g. DMA engine and host register interface) and a shared buffer RAM.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 10, RAM address width; depth is 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request; held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_WIDTH  requester 0 address.
- wdata0  in  DATA_WIDTH  requester 0 write data.
- ack0  out  1  requester 0 request accepted this cycle.
- rdata0  out  DATA_WIDTH  requester 0 read data.
- rvalid0  out  1  rdata0 valid this cycle.
- req1, we1, addr1, wdata1, ack1, rdata1, rvalid1: same as requester 0, for requester 1.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM read data; valid 2 edges after the address edge.

Behaviour:
- Reset: all outputs 0 while rst is high.
- Reset state: last_grant = 1 (requester 0 wins first contention); read-tag pipeline cleared.
- ram_en = ~rst. The RAM pipeline never stalls, so read latency is fixed.
- Arbitration is combinational in each cycle:
  - Only one req high: that requester is granted.
  - Both high: grant the requester not equal to last_grant.
  - On each grant edge, last_grant is updated to the granted index.
  - Neither high: no grant, last_grant holds.
- Grant cycle outputs:
  - ack of the winner = 1; the loser's ack = 0.
  - ram_waddr = ram_raddr = winner addr; ram_din = winner wdata; ram_we = winner we.
  - No grant: ram_we = 0; address/data outputs hold their last value (don't-care).
- Requester rules:
  - Holds req, we, addr, wdata stable until it sees ack.
  - May present a new request in the cycle after ack; back-to-back acks are allowed.
- Throughput:
  - One access per cycle total.
  - Under continuous contention, grants alternate 0,1,0,1…; no starvation.
- Read tag pipeline:
  - 2-stage shift register of {valid, id}. A stage-0 entry is loaded at the grant edge when we = 0.
  - When stage 1 is valid, rvalid[id] = 1 and rdata[id] = ram_dout for exactly one cycle, 2 cycles after the ack cycle.
- rdata of the port without rvalid: holds its previous value; no meaning.
- Writes produce no rvalid.
- Read following a write to the same address, any requester, next cycle or later: returns the new data.
- Write and read ordering is the grant order.
- Reset asserted mid-operation: in-flight reads are discarded, with no rvalid after reset. A write already accepted before reset remains in RAM.
- Address wrap: none; the address is used unmodified. Full 0..2^ADDR_WIDTH-1 range is legal.

Test Plan:
- Reset, then req0 write addr 5 data 0xA5A5A5A5 → ack0 same cycle, ram_we = 1, no rvalid.
  - Then req0 read addr 5 → rvalid0 exactly 2 cycles after ack0, rdata0 = 0xA5A5A5A5.
- req0 and req1 held high continuously for 6 cycles (reads of addrs 1 and 2) → acks 0,1,0,1,0,1.
  - rvalid0/rvalid1 alternate with the matching data.
  - Never both ack high in one cycle.
- req1 alone for 3 cycles, then both high → req0 granted first in the contended cycle (last_grant = 1).
- req1 writes addr 0x3FF = 0x12345678; next cycle req0 reads 0x3FF → rdata0 = 0x12345678, rvalid1 never asserted.
- Issue req0 read, assert rst in the following cycle for 1 cycle → no rvalid0 at any time.
  - All outputs 0 while in reset; first post-reset contention is granted to req0.
- Random interleaved reads/writes from both ports for 1000 cycles against a scoreboard model → every read returns the last written value in grant order.
